// File: rtl/vm_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : vm_pkg
//  Description : Constants and types shared by the vending-machine front end
//                and vending_machine: coin encodings, coin values, credit
//                ceiling and the accumulator state enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package vm_pkg;

  // Coin-type encodings as produced by the coin acceptor
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b01;
  localparam logic [1:0] COIN_TWO  = 2'b10;
  localparam logic [1:0] COIN_FIVE = 2'b11;

  // Credit units contributed by each coin
  localparam int VAL_ONE  = 1;
  localparam int VAL_TWO  = 2;
  localparam int VAL_FIVE = 5;

  // Highest credit the accumulator may hold
  localparam int CREDIT_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_REFUND  = 2'd3
  } state_t;

endpackage : vm_pkg
`default_nettype wire

// File: rtl/coin_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : coin_decoder
//  Description : Combinational coin-type decoder. Returns the credit value of
//                a coin and flags the invalid encoding (value 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_decoder
  import vm_pkg::*;
#(
  parameter int VAL_W = 4
) (
  input  logic [1:0]       i_coin_type,
  output logic [VAL_W-1:0] o_value,
  output logic             o_invalid
);

  // Map each coin encoding to its unit value; unknown codes are invalid
  always_comb begin
    o_value   = '0;
    o_invalid = 1'b0;
    case (i_coin_type)
      COIN_ONE:  o_value = VAL_W'(VAL_ONE);
      COIN_TWO:  o_value = VAL_W'(VAL_TWO);
      COIN_FIVE: o_value = VAL_W'(VAL_FIVE);
      default:   o_invalid = 1'b1;
    endcase
  end

endmodule : coin_decoder
`default_nettype wire

// File: rtl/coin_credit_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : coin_credit_accumulator
//  Description : Vending front end. Accumulates coin credit (saturating, no
//                wrap), latches the item button and presents a held order
//                window to vending_machine; handles cancel/refund.
//                Optional idle auto-refund enabled by defining IDLE_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_credit_accumulator
  import vm_pkg::*;
#(
  parameter int CREDIT_W       = 4,
  parameter int ISSUE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMEOUT_W      = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                btn_valid,
  input  logic [1:0]          btn_item,
  input  logic                btn_cancel,
  output logic [1:0]          item_select,
  output logic [CREDIT_W-1:0] money_inserted,
  output logic                order_valid,
  output logic                coin_reject,
  output logic                refund_valid,
  output logic [CREDIT_W-1:0] refund_amount,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

`ifdef IDLE_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  localparam int ISSUE_W = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;

  state_t                r_state;
  logic [CREDIT_W-1:0]   r_credit;
  logic [CREDIT_W-1:0]   r_money;
  logic [1:0]            r_item;
  logic                  r_order_valid;
  logic                  r_coin_reject;
  logic                  r_refund_valid;
  logic [CREDIT_W-1:0]   r_refund_amount;
  logic                  r_busy;
  logic [ISSUE_W-1:0]    r_issue_cnt;
  logic [TIMEOUT_W-1:0]  r_to_cnt;

  logic [CREDIT_W-1:0]   w_coin_val;
  logic                  w_coin_invalid;
  logic [CREDIT_W:0]     w_sum;
  logic                  w_coin_ok;
  logic                  w_coin_bad;
  logic                  w_timeout;

  coin_decoder #(
    .VAL_W (CREDIT_W)
  ) u_coin_decoder (
    .i_coin_type (coin_type),
    .o_value     (w_coin_val),
    .o_invalid   (w_coin_invalid)
  );

  // One bit wider than the credit so an overflowing coin is detected, not wrapped
  assign w_sum      = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_coin_ok  = coin_valid && !w_coin_invalid && (w_sum <= (CREDIT_W+1)'(CREDIT_MAX));
  assign w_coin_bad = coin_valid && !w_coin_ok;
  // Constant-false when the timeout is not built in, so the counter is pruned
  assign w_timeout  = TIMEOUT_ON && (r_to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  // Control FSM with all outputs registered; pulses default low every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_credit        <= '0;
      r_money         <= '0;
      r_item          <= '0;
      r_order_valid   <= 1'b0;
      r_coin_reject   <= 1'b0;
      r_refund_valid  <= 1'b0;
      r_refund_amount <= '0;
      r_busy          <= 1'b0;
      r_issue_cnt     <= '0;
      r_to_cnt        <= '0;
    end else begin
      r_coin_reject   <= 1'b0;
      r_refund_valid  <= 1'b0;
      r_refund_amount <= '0;
      case (r_state)
        ST_IDLE: begin
          // Button and cancel mean nothing without credit
          if (w_coin_ok) begin
            r_credit <= w_sum[CREDIT_W-1:0];
            r_to_cnt <= '0;
            r_state  <= ST_COLLECT;
          end
          r_coin_reject <= w_coin_bad;
        end
        ST_COLLECT: begin
          if (btn_cancel) begin
            // Cancel wins over everything; a coin offered with it is returned
            r_state         <= ST_REFUND;
            r_refund_valid  <= 1'b1;
            r_refund_amount <= r_credit;
            r_busy          <= 1'b1;
            r_coin_reject   <= coin_valid;
            r_to_cnt        <= '0;
          end else begin
            if (w_coin_ok) begin
              r_credit <= w_sum[CREDIT_W-1:0];
            end
            r_coin_reject <= w_coin_bad;
            if (btn_valid) begin
              // Order carries the credit including a coin accepted this cycle
              r_state       <= ST_ISSUE;
              r_money       <= w_coin_ok ? w_sum[CREDIT_W-1:0] : r_credit;
              r_item        <= btn_item;
              r_order_valid <= 1'b1;
              r_busy        <= 1'b1;
              r_issue_cnt   <= '0;
              r_to_cnt      <= '0;
            end else if (w_coin_ok) begin
              r_to_cnt <= '0;
            end else if (w_timeout) begin
              r_state         <= ST_REFUND;
              r_refund_valid  <= 1'b1;
              r_refund_amount <= r_credit;
              r_busy          <= 1'b1;
              r_to_cnt        <= '0;
            end else if (TIMEOUT_ON) begin
              r_to_cnt <= r_to_cnt + TIMEOUT_W'(1);
            end
          end
        end
        ST_ISSUE: begin
          r_coin_reject <= coin_valid;
          if (r_issue_cnt == ISSUE_W'(ISSUE_CYCLES - 1)) begin
            // Window closes; item_select keeps the last item on purpose
            r_state       <= ST_IDLE;
            r_credit      <= '0;
            r_money       <= '0;
            r_order_valid <= 1'b0;
            r_busy        <= 1'b0;
          end else begin
            r_issue_cnt <= r_issue_cnt + ISSUE_W'(1);
          end
        end
        default: begin
          // Refund pulse has been shown for one cycle; credit is now returned
          r_coin_reject <= coin_valid;
          r_state       <= ST_IDLE;
          r_credit      <= '0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign item_select    = r_item;
  assign money_inserted = r_money;
  assign order_valid    = r_order_valid;
  assign coin_reject    = r_coin_reject;
  assign refund_valid   = r_refund_valid;
  assign refund_amount  = r_refund_amount;
  assign credit         = r_credit;
  assign busy           = r_busy;

endmodule : coin_credit_accumulator
`default_nettype wire

// File: tb/tb_coin_credit_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_credit_accumulator
//  Description : Self-checking bench for coin_credit_accumulator: directed
//                scenarios with literal expectations plus random traffic,
//                compared each cycle against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_credit_accumulator;

  localparam int CW = 4;
  localparam int IC = 2;
  localparam int TC = 8;
  localparam int TW = 4;
`ifdef IDLE_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          coin_valid = 1'b0;
  logic [1:0]    coin_type = 2'b00;
  logic          btn_valid = 1'b0;
  logic [1:0]    btn_item = 2'b00;
  logic          btn_cancel = 1'b0;
  logic [1:0]    item_select;
  logic [CW-1:0] money_inserted;
  logic          order_valid;
  logic          coin_reject;
  logic          refund_valid;
  logic [CW-1:0] refund_amount;
  logic [CW-1:0] credit;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: credit held, cycles left in the order window, refund in progress
  int m_credit, m_left, m_idle, m_money, m_item, m_ramt;
  bit m_refunding, m_rej, m_rv;

  coin_credit_accumulator #(
    .CREDIT_W       (CW),
    .ISSUE_CYCLES   (IC),
    .TIMEOUT_CYCLES (TC),
    .TIMEOUT_W      (TW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .coin_valid     (coin_valid),
    .coin_type      (coin_type),
    .btn_valid      (btn_valid),
    .btn_item       (btn_item),
    .btn_cancel     (btn_cancel),
    .item_select    (item_select),
    .money_inserted (money_inserted),
    .order_valid    (order_valid),
    .coin_reject    (coin_reject),
    .refund_valid   (refund_valid),
    .refund_amount  (refund_amount),
    .credit         (credit),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic int coin_val(input logic [1:0] t);
    case (t)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_refund();
    m_refunding = 1'b1;
    m_rv        = 1'b1;
    m_ramt      = m_credit;
    m_idle      = 0;
  endtask

  // Advance the model by one clock using the inputs sampled at that edge
  task automatic model_step();
    int v;
    bit acc;
    if (reset) begin
      m_credit = 0; m_left = 0; m_idle = 0; m_money = 0; m_item = 0;
      m_ramt = 0; m_refunding = 0; m_rej = 0; m_rv = 0;
      return;
    end
    m_rej = 1'b0; m_rv = 1'b0; m_ramt = 0;
    v = coin_val(coin_type);
    if (m_left > 0) begin
      m_rej = coin_valid;
      m_left--;
      if (m_left == 0) begin
        m_credit = 0;
        m_money  = 0;
      end
    end else if (m_refunding) begin
      m_rej       = coin_valid;
      m_refunding = 1'b0;
      m_credit    = 0;
    end else if (m_credit == 0) begin
      if (coin_valid) begin
        if (v != 0) begin
          m_credit = v;
          m_idle   = 0;
        end else begin
          m_rej = 1'b1;
        end
      end
    end else if (btn_cancel) begin
      start_refund();
      m_rej = coin_valid;
    end else begin
      acc = 1'b0;
      if (coin_valid) begin
        if (v != 0 && m_credit + v <= 15) begin
          m_credit += v;
          acc = 1'b1;
        end else begin
          m_rej = 1'b1;
        end
      end
      if (btn_valid) begin
        m_left  = IC;
        m_money = m_credit;
        m_item  = int'(btn_item);
        m_idle  = 0;
      end else if (acc) begin
        m_idle = 0;
      end else if (TO_ON && m_idle == TC - 1) begin
        start_refund();
      end else begin
        m_idle++;
      end
    end
  endtask

  task automatic compare_all();
    chk("credit",         int'(credit),         m_credit);
    chk("money_inserted", int'(money_inserted), m_money);
    chk("item_select",    int'(item_select),    m_item);
    chk("order_valid",    int'(order_valid),    int'(m_left > 0));
    chk("coin_reject",    int'(coin_reject),    int'(m_rej));
    chk("refund_valid",   int'(refund_valid),   int'(m_rv));
    chk("refund_amount",  int'(refund_amount),  m_ramt);
    chk("busy",           int'(busy),           int'(m_left > 0 || m_refunding));
  endtask

  // Drive one cycle of inputs, step the model at the edge, compare mid-cycle
  task automatic cyc(input bit cv, input logic [1:0] ct, input bit bv,
                     input logic [1:0] bi, input bit cn, input bit rs);
    coin_valid = cv; coin_type = ct; btn_valid = bv; btn_item = bi;
    btn_cancel = cn; reset = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic coin(input logic [1:0] t);
    cyc(1'b1, t, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset state
    do_reset();
    do_reset();
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy",   int'(busy),   0);

    // Two fives then item 01: order of 10 held for IC cycles
    coin(2'b11); coin(2'b11);
    chk("t1_credit", int'(credit), 10);
    cyc(1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0);
    chk("t1_money", int'(money_inserted), 10);
    chk("t1_item",  int'(item_select), 1);
    chk("t1_order", int'(order_valid), 1);
    idle(1);
    chk("t1_order2", int'(order_valid), 1);
    idle(1);
    chk("t1_money_end",  int'(money_inserted), 0);
    chk("t1_credit_end", int'(credit), 0);
    chk("t1_item_kept",  int'(item_select), 1);

    // Saturation at 15 and invalid coin
    do_reset();
    coin(2'b11); coin(2'b11); coin(2'b11);
    coin(2'b01);
    chk("t2_reject", int'(coin_reject), 1);
    chk("t2_credit", int'(credit), 15);
    coin(2'b00);
    chk("t2_reject00", int'(coin_reject), 1);
    chk("t2_credit00", int'(credit), 15);

    // 2 + 1 then cancel
    do_reset();
    coin(2'b10); coin(2'b01);
    cyc(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
    chk("t3_refund_v", int'(refund_valid), 1);
    chk("t3_refund_a", int'(refund_amount), 3);
    idle(1);
    chk("t3_credit", int'(credit), 0);
    chk("t3_refund_v_low", int'(refund_valid), 0);
    chk("t3_busy", int'(busy), 0);

    // Coin and button together; coin during the order window
    do_reset();
    coin(2'b11);
    cyc(1'b1, 2'b10, 1'b1, 2'b10, 1'b0, 1'b0);
    chk("t4_money", int'(money_inserted), 7);
    chk("t4_item",  int'(item_select), 2);
    coin(2'b01);
    chk("t4_reject", int'(coin_reject), 1);
    chk("t4_credit", int'(credit), 7);
    idle(2);

    // Reset during the second order cycle, then button with no credit
    coin(2'b11);
    cyc(1'b0, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1);
    chk("t5_order", int'(order_valid), 0);
    chk("t5_money", int'(money_inserted), 0);
    chk("t5_refund", int'(refund_valid), 0);
    cyc(1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0);
    chk("t5_btn_ignored", int'(order_valid), 0);

    // Idle behaviour with credit held
    coin(2'b11);
`ifdef IDLE_TIMEOUT_EN
    idle(TC - 1);
    chk("t6_no_refund_yet", int'(refund_valid), 0);
    idle(1);
    chk("t6_refund_v", int'(refund_valid), 1);
    chk("t6_refund_a", int'(refund_amount), 5);
    idle(1);
    coin(2'b11);
    idle(5);
    coin(2'b01);
    idle(TC - 1);
    chk("t6_restart", int'(refund_valid), 0);
    idle(1);
    chk("t6_refund_a2", int'(refund_amount), 6);
`else
    idle(50);
    chk("t6_held_credit", int'(credit), 5);
    chk("t6_no_refund",   int'(refund_valid), 0);
`endif
    idle(2);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 40, 2'($urandom_range(0, 3)),
          $urandom_range(0, 99) < 15, 2'($urandom_range(0, 3)),
          $urandom_range(0, 99) < 6,  $urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_coin_credit_accumulator
`default_nettype wire
